moore_seq_detector: RTL and testbench
=====================================

// Module: moore_seq_detector
// PURPOSE
//  Parametrised Moore-type serial sequence detector for the 1-bit input stream.
//  - Detects a compile-time pattern of any length, not only the fixed 1011 case.
//  - Runtime mode selects overlapping or non-overlapping detection.
//  - Clock-enable gating; optional saturating match counter.
//  - Sits after the serial bit source; out feeds downstream control/event logic.
// PARAMETERS
//  PAT_LEN   4        pattern length in bits, >= 2
//  PATTERN   4'b1011  pattern [PAT_LEN-1:0]; PATTERN[PAT_LEN-1] must be received first
//  CNT_W     8        match counter width (used only with MOORE_SEQ_CNT_EN), >= 1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-low
//  en         in   1      1: sample in this edge; 0: hold all state
//  in         in   1      serial data bit
//  overlap    in   1      1: overlapping detection; 0: non-overlapping
//  out        out  1      registered Moore output, 1 while FSM is in state S_PAT_LEN
//  match_cnt  out  CNT_W  saturating match count (present only with MOORE_SEQ_CNT_EN)
// BEHAVIOUR
//  - Reset (rst=0, async, no clock needed): state=S0, out=0, match_cnt=0.
//  - FSM states S0..S_PAT_LEN; S_k = last k sampled bits equal the first k
//    pattern bits. Encoding: binary, $clog2(PAT_LEN+1) bits.
//  - Next state (en=1), computed combinationally from the elaboration-time
//    failure (longest proper prefix-suffix) table:
//    - from S_k, k<PAT_LEN: longest prefix of PATTERN that is a suffix of
//      (matched k bits, in).
//    - from S_PAT_LEN, overlap=1: start from S_f (f = failure of the full
//      pattern), then apply in as above.
//    - from S_PAT_LEN, overlap=0: start from S0, then apply in.
//  - en=0: state, out and match_cnt hold; in is ignored.
//  - out = (state==S_PAT_LEN), decoded from the state register only; no
//    combinational path from in to out.
//  - Latency: edge N samples the final pattern bit; out is 1 from edge N until
//    the next enabled edge. With en held low, out stays 1.
//  - overlap is sampled on each enabled edge and may change at any time;
//    a change takes effect at the next enabled edge.
//  - Reset mid-pattern: partial match is discarded; detection restarts from S0
//    on the first enabled edge after rst deasserts.
// CONFIGURATION
//  MOORE_SEQ_CNT_EN defined:
//  - match_cnt port present.
//  - Increments by 1 on each enabled edge whose next state is S_PAT_LEN.
//  - Saturates at 2**CNT_W-1 (no wrap-around).
//  - Cleared only by rst.
//  MOORE_SEQ_CNT_EN undefined:
//  - match_cnt port and counter logic are absent.
//  - out behaviour is identical in both builds.
// TESTING
//  1. rst=0 for 10ns, then release, en=1 -> out=0 and match_cnt=0 during and
//     immediately after reset.
//  2. Defaults, overlap=1, in=1,0,1,1,0,1,1 -> out high for one cycle after
//     bit 4 and after bit 7; match_cnt=2.
//  3. Defaults, overlap=0, in=1,0,1,1,0,1,1 -> out high after bit 4 only;
//     match_cnt=1.
//  4. PAT_LEN=3, PATTERN=3'b111, in=1 x5:
//     overlap=1 -> out high after bits 3, 4, 5.
//     overlap=0 -> out high after bit 3 only.
//  5. Defaults, in=1,0,1 then en=0 for 3 cycles with in=0, then en=1, in=1
//     -> out high one cycle after the final enabled edge.
//  6. Defaults, in=1,0,1, then rst pulse low mid-cycle, then 1 -> no match.
//     Then CNT_W=2 with 5 overlapping matches -> match_cnt saturates at 3.

Source files
------------

// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector for an arbitrary compile-time pattern.
// The first received bit of the pattern is PATTERN[PAT_LEN-1].
// Runtime overlap select, clock enable, registered output.
// Optional saturating match counter: define MOORE_SEQ_CNT_EN to include it.
module moore_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  output logic             out
`ifdef MOORE_SEQ_CNT_EN
  ,output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NT = 2 ** SW;

  typedef logic [SW-1:0] state_t;

  // Pattern bit in receive order: index 0 is the first bit on the wire.
  function automatic logic pat_bit(int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, b).
  function automatic int delta(int k, logic b);
    int   best;
    int   si;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          si = k + 1 - j + i;
          sb = (si == k) ? b : pat_bit(si);
          if (sb != pat_bit(i)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int fail_full();
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j < PAT_LEN; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (pat_bit(i) != pat_bit(PAT_LEN - j + i)) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam state_t S_FULL = SW'(PAT_LEN);
  localparam state_t S_FAIL = SW'(fail_full());

  // Transition table for states S0..S_{PAT_LEN-1}, built at elaboration.
  // Sized to the full state-code range so indexing needs no range guard.
  state_t tab0 [NT];
  state_t tab1 [NT];

  for (genvar k = 0; k < NT; k++) begin : g_tab
    if (k < PAT_LEN) begin : g_v
      assign tab0[k] = SW'(delta(k, 1'b0));
      assign tab1[k] = SW'(delta(k, 1'b1));
    end else begin : g_z
      assign tab0[k] = '0;
      assign tab1[k] = '0;
    end
  end

  state_t state_q, state_d, base;

  // Next state: a full match first falls back (to S_FAIL or S0), then takes in.
  always_comb begin
    base = state_q;
    if (state_q == S_FULL) base = overlap ? S_FAIL : '0;
    state_d = in ? tab1[base] : tab0[base];
  end

  // State register, held while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state_q <= '0;
    else if (en) state_q <= state_d;
  end

  assign out = (state_q == S_FULL);

`ifdef MOORE_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count enabled edges that land in the full-match state, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_FULL && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt_q <= '0;
    else if (en) cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: three instances share one stimulus stream.
//   a: defaults (1011, CNT_W=8)   b: PAT_LEN=3, 111   c: 1011 with CNT_W=2
// A history-based model (shift register of received bits) predicts every
// output each cycle; directed literal checks pin the model.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic din = 1'b0;
  logic ovl = 1'b0;
  logic out_a, out_b, out_c;
`ifdef MOORE_SEQ_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] cnt_c;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  moore_seq_detector u_a (
    .clk(clk), .rst(rst), .en(en), .in(din), .overlap(ovl), .out(out_a)
`ifdef MOORE_SEQ_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  moore_seq_detector #(.PAT_LEN(3), .PATTERN(3'b111)) u_b (
    .clk(clk), .rst(rst), .en(en), .in(din), .overlap(ovl), .out(out_b)
`ifdef MOORE_SEQ_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  moore_seq_detector #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .in(din), .overlap(ovl), .out(out_c)
`ifdef MOORE_SEQ_CNT_EN
    , .match_cnt(cnt_c)
`endif
  );

  // Model: bit history since the last restart; a match is the last L bits
  // equal to the pattern. Non-overlapping mode forgets the history after a match.
  int m_len [3] = '{4, 3, 4};
  int m_pat [3] = '{11, 7, 11};
  int m_max [3] = '{255, 255, 3};
  int m_sh  [3];
  int m_n   [3];
  int m_out [3];
  int m_cnt [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        m_sh[d] = 0; m_n[d] = 0; m_out[d] = 0; m_cnt[d] = 0;
      end
    end else if (en) begin
      for (int d = 0; d < 3; d++) begin
        if (m_out[d] == 1 && ovl == 1'b0) begin
          m_sh[d] = 0; m_n[d] = 0;
        end
        m_sh[d] = ((m_sh[d] << 1) | int'(din)) & 255;
        m_n[d]  = m_n[d] + 1;
        m_out[d] = (m_n[d] >= m_len[d] &&
                    (m_sh[d] & ((1 << m_len[d]) - 1)) == m_pat[d]) ? 1 : 0;
        if (m_out[d] == 1 && m_cnt[d] < m_max[d]) m_cnt[d] = m_cnt[d] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model out_a", int'(out_a), m_out[0]);
    chk("model out_b", int'(out_b), m_out[1]);
    chk("model out_c", int'(out_c), m_out[2]);
`ifdef MOORE_SEQ_CNT_EN
    chk("model cnt_a", int'(cnt_a), m_cnt[0]);
    chk("model cnt_b", int'(cnt_b), m_cnt[1]);
    chk("model cnt_c", int'(cnt_c), m_cnt[2]);
`endif
  end

  // One enabled bit; sample 1 ns after the edge that took it.
  task automatic send(input logic b);
    @(negedge clk);
    en = 1'b1; din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic b);
    @(negedge clk);
    en = 1'b0; din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; din = 1'b0;
    #2;
    chk("reset out_a", int'(out_a), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int seq7  [7] = '{1, 0, 1, 1, 0, 1, 1};
  int exp_o [7] = '{0, 0, 0, 1, 0, 0, 1};
  int exp_n [7] = '{0, 0, 0, 1, 0, 0, 0};
  int exp_b1[5] = '{0, 0, 1, 1, 1};
  int exp_b0[5] = '{0, 0, 1, 0, 0};

  initial begin
    // 1: reset behaviour
    #3;
    chk("reset out_a", int'(out_a), 0);
    chk("reset out_b", int'(out_b), 0);
`ifdef MOORE_SEQ_CNT_EN
    chk("reset cnt_a", int'(cnt_a), 0);
`endif
    #7 rst = 1'b1;
    en = 1'b1;
    #1;
    chk("post-reset out_a", int'(out_a), 0);

    // 2: overlapping 1011 stream
    do_reset(); ovl = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(seq7[i][0]);
      chk($sformatf("ovl1 bit%0d", i + 1), int'(out_a), exp_o[i]);
    end
`ifdef MOORE_SEQ_CNT_EN
    chk("ovl1 cnt_a", int'(cnt_a), 2);
`endif

    // 3: non-overlapping 1011 stream
    do_reset(); ovl = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(seq7[i][0]);
      chk($sformatf("ovl0 bit%0d", i + 1), int'(out_a), exp_n[i]);
    end
`ifdef MOORE_SEQ_CNT_EN
    chk("ovl0 cnt_a", int'(cnt_a), 1);
`endif

    // 4: pattern 111, five ones, both modes
    do_reset(); ovl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      chk($sformatf("111 ovl1 bit%0d", i + 1), int'(out_b), exp_b1[i]);
    end
    do_reset(); ovl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      chk($sformatf("111 ovl0 bit%0d", i + 1), int'(out_b), exp_b0[i]);
    end

    // 5: enable gating mid-pattern, then hold of a match
    do_reset(); ovl = 1'b1;
    send(1'b1); send(1'b0); send(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("gated hold low", int'(out_a), 0);
    end
    send(1'b1);
    chk("gated match", int'(out_a), 1);
    idle(1'b0);
    idle(1'b1);
    chk("gated hold high", int'(out_a), 1);
    send(1'b0);
    chk("after hold", int'(out_a), 0);

    // 6: reset pulse mid-pattern discards the partial match
    do_reset(); ovl = 1'b1;
    send(1'b1); send(1'b0); send(1'b1);
    #2 rst = 1'b0;
    #1 chk("mid reset out_a", int'(out_a), 0);
    #1 rst = 1'b1;
    send(1'b1);
    chk("no match after reset", int'(out_a), 0);

    // 6b: five overlapping matches saturate the 2-bit counter
    do_reset(); ovl = 1'b1;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b0); send(1'b1); send(1'b1);
    end
    chk("sat out_a", int'(out_a), 1);
`ifdef MOORE_SEQ_CNT_EN
    chk("sat cnt_a", int'(cnt_a), 5);
    chk("sat cnt_c", int'(cnt_c), 3);
`endif

    // runtime overlap change right at a match
    do_reset(); ovl = 1'b1;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    ovl = 1'b0;
    send(1'b0); send(1'b1); send(1'b1);
    chk("ovl switch", int'(out_a), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
